fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Holds the PC, selects the next PC (sequential, branch, jump, jump-register) from decode-stage redirect signals, and runs a single-outstanding request/response handshake with a variable-latency instruction memory.
- Presents instrD, pc_plus_4_decoded and validD to decode.
- Honours stall and flush from the hazard unit.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction driven into IF/ID for a bubble.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stallF  in  1  hazard: hold the PC and do not advance fetch
- stallD  in  1  hazard: hold the IF/ID register
- flushD  in  1  hazard: load a bubble into IF/ID
- pcsrcD  in  1  taken-branch indication from decode
- branch_addrD  in  32  branch target from decode
- jumpD  in  1  jump indication from decode
- jump_addrD  in  32  jump target from decode
- jrD  in  1  jump-register indication from decode
- jr_addrD  in  32  jump-register target from decode
- imem_req  out  1  instruction memory request valid
- imem_addr  out  32  request address, word aligned
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid
- imem_rdata  in  32  response instruction
- instrD  out  32  IF/ID instruction
- pc_plus_4_decoded  out  32  IF/ID PC+4
- validD  out  1  IF/ID holds a real instruction
- fetch_busy  out  1  high in every state except HOLD

Behaviour:
- Reset, asynchronous, active low:
  - pcF=RESET_PC; state=REQ; buffer empty.
  - instrD=NOP_INSTR, pc_plus_4_decoded=RESET_PC+4, validD=0.
  - imem_req is not asserted until the first clock after reset deassertion.
  - Responses arriving while in REQ are ignored. This covers responses to requests issued before a mid-operation reset.
- FSM states:
  - REQ: imem_req=1, imem_addr=pcF. On imem_gnt go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid:
    - If kill=1: discard the response, clear kill, go to REQ.
    - Else if stallF or stallD: latch imem_rdata into the buffer, go to HOLD.
    - Else: load IF/ID with {imem_rdata, pcF+4, valid=1}, set pcF=pcF+4, go to REQ.
  - HOLD: the buffered instruction waits. When stallF=0 and stallD=0, load IF/ID from the buffer, set pcF=pcF+4, go to REQ.
- Redirect:
  - Condition: redir = validD & ~stallD & (jrD | jumpD | pcsrcD).
  - Target priority: jrD > jumpD > pcsrcD. Target bits [1:0] are forced to 00.
  - On redir:
    - pcF = target.
    - IF/ID loads a bubble (NOP_INSTR, validD=0).
    - A held buffer is dropped; state goes to REQ.
    - In WAIT: kill=1; state stays WAIT until the stale response returns.
    - In REQ with imem_gnt in the same cycle: go to WAIT with kill=1.
  - Redirect overrides stallF.
  - No delay slot: the sequential successor of a taken control transfer never reaches decode.
- IF/ID register:
  - flushD=1 loads a bubble. flushD wins over stallD.
  - stallD=1 and flushD=0 holds all three IF/ID outputs.
  - In any cycle where nothing new is delivered and IF/ID is not stalled, IF/ID loads a bubble (validD=0). A fetch that is waiting on memory therefore appears as bubbles to decode.
- Arithmetic:
  - pcF+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
  - pc_plus_4_decoded always equals the delivered instruction's PC+4, including bubbles.
- Single outstanding request only; imem_req is never asserted in WAIT or HOLD.
- Latency: with gnt in the same cycle and rvalid one cycle later, the best case is one instruction per 2 cycles.

Decomposition:
- Shared package holds:
  - RESET_PC and NOP_INSTR defaults.
  - Fetch state encoding: REQ=2'd0, WAIT=2'd1, HOLD=2'd2.
- One sub-module, if_id_reg: the IF/ID pipeline register with stall/flush/bubble priority. It is reusable for other stage registers.
- Next-PC selection stays inline.

Test Plan:
- Reset release, memory returning 32'h2008_0005 at 0x0040_0000 with gnt same cycle and rvalid +1 -> imem_addr=0x0040_0000, then instrD=32'h2008_0005, pc_plus_4_decoded=0x0040_0004, validD=1; next request to 0x0040_0004.
- stallD held 3 cycles while a response arrives -> state HOLD, fetch_busy=0, IF/ID unchanged; on release the buffered word is delivered once, with no duplicate and no loss.
- Taken branch (pcsrcD=1, branch_addrD=0x0040_0100) while a fetch to 0x0040_0008 is in WAIT -> stale response discarded, validD=0 for the redirect cycle, next imem_addr=0x0040_0100.
- jrD=1 and jumpD=1 asserted together (jr_addrD=0x0040_0200, jump_addrD=0x0040_0300) -> pcF=0x0040_0200; and jr_addrD=0x0040_0203 -> imem_addr=0x0040_0200.
- flushD=1 and stallD=1 in the same cycle -> instrD=NOP_INSTR, validD=0; and pcF=0xFFFF_FFFC delivered -> pc_plus_4_decoded=0, next imem_addr=0.
- rst_n pulsed low mid-WAIT, then rvalid arrives after release -> outputs at reset values and the response is ignored; the first new request goes to 0x0040_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Holds reset PC / bubble defaults and the fetch FSM encoding.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0040_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register between fetch and decode (instr, pc+4, valid).
// Ports: stall/flush/load controls, incoming word, bubble pc+4, outputs.
module if_id_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        load,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_plus_4_in,
   input  logic [31:0] bubble_pc_plus_4,
   output logic [31:0] instr,
   output logic [31:0] pc_plus_4,
   output logic        valid
);

   // flush beats stall; an idle unstalled cycle becomes a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr     <= NOP_INSTR;
         pc_plus_4 <= RESET_PC + 32'd4;
         valid     <= 1'b0;
      end else if (flush) begin
         instr     <= NOP_INSTR;
         pc_plus_4 <= bubble_pc_plus_4;
         valid     <= 1'b0;
      end else if (stall) begin
         instr     <= instr;
         pc_plus_4 <= pc_plus_4;
         valid     <= valid;
      end else if (load) begin
         instr     <= instr_in;
         pc_plus_4 <= pc_plus_4_in;
         valid     <= 1'b1;
      end else begin
         instr     <= NOP_INSTR;
         pc_plus_4 <= bubble_pc_plus_4;
         valid     <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC select, single-outstanding imem handshake.
// Ports: hazard stall/flush, decode redirects, imem req/gnt/rvalid, IF/ID out.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stallF,
   input  logic        stallD,
   input  logic        flushD,
   input  logic        pcsrcD,
   input  logic [31:0] branch_addrD,
   input  logic        jumpD,
   input  logic [31:0] jump_addrD,
   input  logic        jrD,
   input  logic [31:0] jr_addrD,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instrD,
   output logic [31:0] pc_plus_4_decoded,
   output logic        validD,
   output logic        fetch_busy
);

   fetch_state_t state, state_n;
   logic [31:0]  pc_f, pc_n;
   logic [31:0]  buf_q, buf_n;
   logic         kill, kill_n;
   logic         started;

   logic [31:0]  pc_plus_4_f;
   logic [31:0]  target;
   logic [31:0]  target_al;
   logic         redir;
   logic         stall_any;
   logic         load;
   logic [31:0]  load_instr;
   logic         req;

   assign pc_plus_4_f = pc_f + 32'd4;
   assign stall_any   = stallF | stallD;
   assign redir       = validD & ~stallD & (jrD | jumpD | pcsrcD);
   assign target_al   = target & ~32'h3;

   always_comb begin
      target = branch_addrD;
      if (jrD)
         target = jr_addrD;
      else if (jumpD)
         target = jump_addrD;
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc_f;
      kill_n     = kill;
      buf_n      = buf_q;
      load       = 1'b0;
      load_instr = buf_q;
      req        = 1'b0;
      unique case (state)
         REQ: begin
            // no request until one clock after reset release
            req = started;
            if (req && imem_gnt) begin
               state_n = WAIT;
               kill_n  = redir;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (kill || redir) begin
                  kill_n  = 1'b0;
                  state_n = REQ;
               end else if (stall_any) begin
                  buf_n   = imem_rdata;
                  state_n = HOLD;
               end else begin
                  load       = 1'b1;
                  load_instr = imem_rdata;
                  pc_n       = pc_plus_4_f;
                  state_n    = REQ;
               end
            end else if (redir) begin
               kill_n = 1'b1;
            end
         end
         HOLD: begin
            if (redir) begin
               state_n = REQ;
            end else if (!stall_any) begin
               load    = 1'b1;
               pc_n    = pc_plus_4_f;
               state_n = REQ;
            end
         end
         default: begin
            state_n = REQ;
            kill_n  = 1'b0;
         end
      endcase
      if (redir)
         pc_n = target_al;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= REQ;
         pc_f    <= RESET_PC & ~32'h3;
         buf_q   <= NOP_INSTR;
         kill    <= 1'b0;
         started <= 1'b0;
      end else begin
         state   <= state_n;
         pc_f    <= pc_n;
         buf_q   <= buf_n;
         kill    <= kill_n;
         started <= 1'b1;
      end
   end

   if_id_reg #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall            (stallD),
      .flush            (flushD | redir),
      .load             (load),
      .instr_in         (load_instr),
      .pc_plus_4_in     (pc_plus_4_f),
      .bubble_pc_plus_4 (pc_plus_4_f),
      .instr            (instrD),
      .pc_plus_4        (pc_plus_4_decoded),
      .valid            (validD)
   );

   assign imem_req   = req;
   assign imem_addr  = pc_f;
   assign fetch_busy = (state != HOLD);

endmodule
